// File: rtl/bus_burst_source.sv
// Burst word generator: takes a (base, length) command and emits that many
// incrementing words on a valid/ready stream, flagging the final beat.
module bus_burst_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_dnt,
  output logic             cmd_ready_dnt,
  input  logic [WIDTH-1:0] cmd_base_dnt,
  input  logic [LEN_W-1:0] cmd_len_dnt,
  output logic             valid_src,
  output logic [WIDTH-1:0] data_src,
  output logic             last_src,
  input  logic             ready_src,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_next;
  logic               valid_next, last_next, done_next;
  logic [WIDTH-1:0]   data_next;
  logic [LEN_W-1:0]   remaining, remaining_next;
  logic               xfer, accept, len_zero;

  assign xfer     = valid_src & ready_src;
  assign accept   = cmd_valid_dnt & cmd_ready_dnt;
  assign len_zero = (cmd_len_dnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A command may be taken on the final beat, so SEND can reload in place.
  always_comb begin
    state_next     = state;
    valid_next     = valid_src;
    data_next      = data_src;
    last_next      = last_src;
    remaining_next = remaining;
    done_next      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (len_zero) begin
            done_next = 1'b1;
          end else begin
            state_next     = SEND;
            valid_next     = 1'b1;
            data_next      = cmd_base_dnt;
            last_next      = (cmd_len_dnt == LEN_W'(1));
            remaining_next = cmd_len_dnt;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last_src) begin
            data_next      = data_src + WIDTH'(1);
            remaining_next = remaining - LEN_W'(1);
            last_next      = (remaining == LEN_W'(2));
          end else begin
            done_next = 1'b1;
            if (accept && !len_zero) begin
              data_next      = cmd_base_dnt;
              last_next      = (cmd_len_dnt == LEN_W'(1));
              remaining_next = cmd_len_dnt;
            end else begin
              state_next     = IDLE;
              valid_next     = 1'b0;
              last_next      = 1'b0;
              remaining_next = '0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_src <= 1'b0;
      data_src  <= '0;
      last_src  <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      valid_src <= valid_next;
      data_src  <= data_next;
      last_src  <= last_next;
      done      <= done_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    busy          = (state == SEND);
    cmd_ready_dnt = (state == IDLE) | (xfer & last_src);
  end

endmodule
